// File: rtl/leaf_user_bridge.sv
// -----------------------------------------------------------------------------
// leaf_user_bridge
//   Buffering bridge between leaf_interface and the user kernel of a leaf shell.
//   Every inbound (interface -> user) and outbound (user -> interface) channel
//   passes through a 2-entry skid buffer. The user-kernel reset is sequenced
//   from ap_start, and the BFT packet output is registered with resend squashing.
//
// Optional feature macro: LEAF_BRIDGE_STALL_CNT_EN
//   When defined, adds the stall_cnt port: one saturating 16-bit counter per
//   outbound channel, counting RUN cycles where the interface stalls a valid word.
//
// Ports
//   clk, reset_n          : clock, synchronous active-low reset
//   ap_start              : level start request (rising edge starts/restarts)
//   user_rst_n, busy      : user-kernel reset (active low), high while running
//   pkt_in, resend        : packet from leaf_interface, squash request
//   pkt_out               : registered packet to the BFT
//   if_din/if_vld/if_ack  : inbound channels, interface side
//   usr_dout/usr_vld/usr_ack : inbound channels, user side
//   usr_din/usr_ovld/usr_oack : outbound channels, user side
//   if_dout/if_ovld/if_oack  : outbound channels, interface side
//   stall_cnt             : per-outbound stall counters (macro only)
// -----------------------------------------------------------------------------

// 2-entry skid buffer. Entry 0 is always the head; entry 1 holds the second word.
module leaf_skid #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_flush,
  input  logic [W-1:0] i_din,
  input  logic         i_vld,
  output logic         o_ack,
  output logic [W-1:0] o_dout,
  output logic         o_vld,
  input  logic         i_ack
);
  logic [1:0]   r_cnt;
  logic         r_ack;
  logic [W-1:0] r_e0;
  logic [W-1:0] r_e1;
  logic         w_push;
  logic         w_pop;
  logic [1:0]   w_cnt_next;

  assign w_push = i_vld & r_ack;
  assign w_pop  = i_ack & (r_cnt != 2'd0);

  assign o_ack  = r_ack;
  assign o_vld  = (r_cnt != 2'd0);
  assign o_dout = r_e0;

  always_comb begin
    // NOTE: assign every always_comb output a default first so no path can infer a latch.
    w_cnt_next = r_cnt;
    if (i_flush)               w_cnt_next = 2'd0;
    else if (w_push && !w_pop) w_cnt_next = r_cnt + 2'd1;
    else if (w_pop && !w_push) w_cnt_next = r_cnt - 2'd1;
  end

  // Ack is registered from the occupancy the buffer will have after this edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      r_cnt <= 2'd0;
      r_ack <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      r_ack <= !i_flush && (w_cnt_next != 2'd2);
    end
  end

  // NOTE: payload registers are not reset; the count alone qualifies them.
  always_ff @(posedge clk) begin
    case ({w_push, w_pop})
      2'b01: r_e0 <= r_e1;
      2'b10: begin
        if (r_cnt == 2'd0) r_e0 <= i_din;
        else               r_e1 <= i_din;
      end
      2'b11: begin
        if (r_cnt == 2'd1) begin
          r_e0 <= i_din;
        end else begin
          r_e0 <= r_e1;
          r_e1 <= i_din;
        end
      end
      default: ;
    endcase
  end
endmodule

module leaf_user_bridge #(
  parameter int PACKET_BITS     = 49,
  parameter int PAYLOAD_BITS    = 32,
  parameter int NUM_IN_PORTS    = 5,
  parameter int NUM_OUT_PORTS   = 3,
  parameter int RST_HOLD_CYCLES = 16
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  ap_start,
  output logic                                  user_rst_n,
  output logic                                  busy,
  input  logic [PACKET_BITS-1:0]                pkt_in,
  input  logic                                  resend,
  output logic [PACKET_BITS-1:0]                pkt_out,
  input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  if_din,
  input  logic [NUM_IN_PORTS-1:0]               if_vld,
  output logic [NUM_IN_PORTS-1:0]               if_ack,
  output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  usr_dout,
  output logic [NUM_IN_PORTS-1:0]               usr_vld,
  input  logic [NUM_IN_PORTS-1:0]               usr_ack,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] usr_din,
  input  logic [NUM_OUT_PORTS-1:0]              usr_ovld,
  output logic [NUM_OUT_PORTS-1:0]              usr_oack,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] if_dout,
  output logic [NUM_OUT_PORTS-1:0]              if_ovld,
  input  logic [NUM_OUT_PORTS-1:0]              if_oack
`ifdef LEAF_BRIDGE_STALL_CNT_EN
  ,output logic [NUM_OUT_PORTS*16-1:0]          stall_cnt
`endif
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_ap_prev;
  logic                   r_start_rise;
  logic [7:0]             r_hold_cnt;
  logic [PACKET_BITS-1:0] r_pkt;
  logic                   w_flush;
  logic                   w_enter_hold;

  // Start edge is registered, so a rise sampled at edge N enters HOLD at N+1.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_ap_prev    <= 1'b0;
      r_start_rise <= 1'b0;
      r_hold_cnt   <= 8'd0;
      r_pkt        <= '0;
    end else begin
      r_state      <= w_state_next;
      r_ap_prev    <= ap_start;
      r_start_rise <= ap_start & ~r_ap_prev;
      if (w_enter_hold)
        r_hold_cnt <= 8'(RST_HOLD_CYCLES - 1);
      else if (r_state == ST_HOLD && r_hold_cnt != 8'd0)
        r_hold_cnt <= r_hold_cnt - 8'd1;
      r_pkt        <= resend ? '0 : pkt_in;
    end
  end

  always_comb begin
    w_state_next = r_state;
    user_rst_n   = 1'b0;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: if (r_start_rise) w_state_next = ST_HOLD;
      ST_HOLD: if (r_hold_cnt == 8'd0) w_state_next = ST_RUN;
      ST_RUN: begin
        user_rst_n = 1'b1;
        busy       = 1'b1;
        if (r_start_rise) w_state_next = ST_HOLD;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Buffers are emptied on the very edge that leaves RUN, so no stale word
  // survives into the restarted kernel.
  assign w_flush      = (w_state_next != ST_RUN);
  assign w_enter_hold = (w_state_next == ST_HOLD) && (r_state != ST_HOLD);
  assign pkt_out      = r_pkt;

  for (genvar k = 0; k < NUM_IN_PORTS; k++) begin : g_in
    leaf_skid #(.W(PAYLOAD_BITS)) u_skid (
      .clk    (clk),
      .reset_n(reset_n),
      .i_flush(w_flush),
      .i_din  (if_din[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .i_vld  (if_vld[k]),
      .o_ack  (if_ack[k]),
      .o_dout (usr_dout[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .o_vld  (usr_vld[k]),
      .i_ack  (usr_ack[k])
    );
  end

  for (genvar k = 0; k < NUM_OUT_PORTS; k++) begin : g_out
    leaf_skid #(.W(PAYLOAD_BITS)) u_skid (
      .clk    (clk),
      .reset_n(reset_n),
      .i_flush(w_flush),
      .i_din  (usr_din[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .i_vld  (usr_ovld[k]),
      .o_ack  (usr_oack[k]),
      .o_dout (if_dout[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .o_vld  (if_ovld[k]),
      .i_ack  (if_oack[k])
    );

`ifdef LEAF_BRIDGE_STALL_CNT_EN
    logic [15:0] r_stall;
    always_ff @(posedge clk) begin
      if (!reset_n || w_enter_hold)
        r_stall <= 16'd0;
      else if (r_state == ST_RUN && if_ovld[k] && !if_oack[k] && r_stall != 16'hFFFF)
        r_stall <= r_stall + 16'd1;
    end
    assign stall_cnt[k*16 +: 16] = r_stall;
`endif
  end
endmodule

// File: doc/leaf_user_bridge.md
# leaf_user_bridge

Parametrised buffering bridge between `leaf_interface` and the user kernel in a leaf shell, replacing the fixed-width direct wiring of the per-port-count shells. It inserts a 2-entry skid buffer on every inbound (interface→user) and outbound (user→interface) channel. It sequences the user-kernel reset from `ap_start`, and registers the BFT packet output with resend squashing. One instance serves any iNoM leaf by parameter choice.

## Interface
Parameters:
- `PACKET_BITS`, 49: BFT packet width.
- `PAYLOAD_BITS`, 32: per-channel data width.
- `NUM_IN_PORTS`, 5: inbound channels, 1..15.
- `NUM_OUT_PORTS`, 3: outbound channels, 1..15.
- `RST_HOLD_CYCLES`, 16: user-reset hold length after start, 1..255.

Ports:
- `clk` in 1: single clock for all logic.
- `reset_n` in 1: synchronous, active-low reset.
- `ap_start` in 1: level start request from the shell.
- `user_rst_n` out 1: active-low reset to the user kernel.
- `busy` out 1: high in RUN.
- `pkt_in` in PACKET_BITS: packet from `leaf_interface`.
- `resend` in 1: squash the outgoing packet.
- `pkt_out` out PACKET_BITS: registered packet to the BFT.
- `if_din` in NUM_IN_PORTS*PAYLOAD_BITS: inbound data from the interface; channel k occupies bits [k*PAYLOAD_BITS +: PAYLOAD_BITS].
- `if_vld` in NUM_IN_PORTS: inbound valid.
- `if_ack` out NUM_IN_PORTS: inbound accept.
- `usr_dout` out NUM_IN_PORTS*PAYLOAD_BITS: inbound data to the user.
- `usr_vld` out NUM_IN_PORTS, `usr_ack` in NUM_IN_PORTS: user-side inbound handshake.
- `usr_din` in NUM_OUT_PORTS*PAYLOAD_BITS, `usr_ovld` in NUM_OUT_PORTS, `usr_oack` out NUM_OUT_PORTS: user-side outbound channels.
- `if_dout` out NUM_OUT_PORTS*PAYLOAD_BITS, `if_ovld` out NUM_OUT_PORTS, `if_oack` in NUM_OUT_PORTS: interface-side outbound channels.
- `stall_cnt` out NUM_OUT_PORTS*16: per-outbound stall counters. Present only with the macro in Configuration.

## Operation
- Handshake: a word transfers on a cycle where vld=1 and ack=1. Data is sampled in that same cycle.
- Each channel has one 2-entry skid buffer with a 2-bit occupancy count:
  - Upstream ack = (count < 2), driven from a register.
  - Downstream vld = (count != 0).
  - Downstream data = head entry.
  - Simultaneous push and pop leaves count unchanged and preserves order.
  - A push when count==2 cannot occur, because ack is low.
  - A pop when count==0 cannot occur, because vld is low.
- Start sequencer, 2-bit state:
  - IDLE: `user_rst_n`=0, `busy`=0. Go to HOLD on an `ap_start` rising edge (previous value registered).
  - HOLD: `user_rst_n`=0. Load the counter with RST_HOLD_CYCLES−1, decrement each cycle, go to RUN when it reaches 0.
  - RUN: `user_rst_n`=1, `busy`=1. A new `ap_start` rising edge goes back to HOLD (restart). `ap_start` falling has no effect.
- In IDLE and HOLD, all skid buffers are flushed (count forced to 0) and all acks are driven 0. Data already in flight is discarded.
- Packet path: `pkt_out` <= resend ? 0 : pkt_in, every cycle, independent of the sequencer state.

## Timing
- Reset (`reset_n`=0 on a rising edge):
  - state=IDLE, all counts=0, every ack=0, every vld=0.
  - `user_rst_n`=0, `busy`=0, `pkt_out`=0, previous `ap_start`=0, `stall_cnt`=0.
- Reset asserted mid-operation discards buffered data on the next edge.
- Channel latency: a word pushed at edge N is visible downstream after edge N, so it is poppable in cycle N+1. Minimum latency is 1 cycle.
- Full throughput is 1 word per cycle per channel.
- Ack reflects occupancy after the previous edge. It goes low one cycle after the second entry fills without a pop.
- `ap_start` rising seen at edge N:
  - HOLD occupies edges N+1..N+RST_HOLD_CYCLES.
  - `user_rst_n`=1 and channel acks become enabled after edge N+RST_HOLD_CYCLES+1.
- `pkt_out` latency is 1 cycle. A `resend` high at edge N zeroes `pkt_out` after edge N.

## Configuration
- Macro: `LEAF_BRIDGE_STALL_CNT_EN`.
- Defined:
  - `stall_cnt` port exists.
  - Counter k increments, saturating at 16'hFFFF, on each RUN cycle with `if_ovld[k]`=1 and `if_oack[k]`=0.
  - Counters clear on reset and on entry to HOLD.
- Undefined: the port and counters are absent. All other behaviour is identical.

## Test plan
- Reset, then `ap_start` 0→1 with RST_HOLD_CYCLES=4 → `user_rst_n` stays 0 for 4 cycles, then 1. `busy`=1 from the same edge. All acks are 0 before that edge.
- RUN, inbound channel 2: push 0xA5A5_0001..0xA5A5_0008 back-to-back with `usr_ack`=1 → all 8 words emerge in order at 1 word/cycle, each delayed 1 cycle.
- RUN, outbound channel 0 with `if_oack`=0: push 3 words → the first two are accepted, `usr_oack[0]` goes 0. Release ack → words 1,2,3 delivered with no loss or duplication. With the macro defined, `stall_cnt[0]` equals the number of stalled cycles.
- `pkt_in`=49'h1_2345_6789_ABCD with `resend` pulsed for 1 cycle → `pkt_out` shows 0 for exactly that one cycle, the value otherwise.
- Second `ap_start` edge while 1 word is buffered per channel → all vld=0 the next cycle, HOLD is re-entered, and the buffered words never appear.
- `reset_n` pulsed low mid-stream → next cycle all outputs are at their reset values and state=IDLE.
